// File: rtl/lcd_ctrl_if.sv
// Host/LCD signal bundle for the character-LCD sequencer.
// The master drives requests; the slave drives ready/status and the LCD pins.
interface lcd_ctrl_if;
   logic       req;
   logic       rs;
   logic [7:0] data;
   logic       ready;
   logic       init_done;
   logic       lcd_on;
   logic       lcd_en;
   logic       lcd_rs;
   logic       lcd_rw;
   logic [7:0] lcd_data;

   modport master (
      output req, rs, data,
      input  ready, init_done, lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_data
   );

   modport slave (
      input  req, rs, data,
      output ready, init_done, lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_data
   );
endinterface

// File: rtl/lcd_ctrl.sv
// HD44780-compatible write-only sequencer: autonomous power-up init, then one
// host byte per valid/ready handshake with timed setup/enable/hold/settle phases.
module lcd_ctrl #(
   parameter int unsigned P_PWRUP_CYC    = 750000,
   parameter int unsigned P_SETUP_CYC    = 2,
   parameter int unsigned P_EN_CYC       = 12,
   parameter int unsigned P_HOLD_CYC     = 2,
   parameter int unsigned P_CMD_WAIT_CYC = 2000,
   parameter int unsigned P_CLR_WAIT_CYC = 82000
) (
   input  logic       i_clk,
   input  logic       i_reset,
   lcd_ctrl_if.slave  bus
);
   localparam int unsigned MAX_A   = (P_PWRUP_CYC > P_CLR_WAIT_CYC) ? P_PWRUP_CYC : P_CLR_WAIT_CYC;
   localparam int unsigned MAX_B   = (P_CMD_WAIT_CYC > P_EN_CYC) ? P_CMD_WAIT_CYC : P_EN_CYC;
   localparam int unsigned MAX_C   = (P_SETUP_CYC > P_HOLD_CYC) ? P_SETUP_CYC : P_HOLD_CYC;
   localparam int unsigned MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned MAX_CYC = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
   localparam int unsigned IDX_W   = 3;

   typedef enum logic [2:0] {
      S_PWRUP, S_SETUP, S_EN_HI, S_HOLD, S_WAIT, S_IDLE
   } state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [IDX_W-1:0] idx, idx_n;
   logic             ready, ready_n;
   logic             done, done_n;
   logic             en, en_n;
   logic             rs, rs_n;
   logic [7:0]       data, data_n;
   logic             lcd_on;
   logic             last_c;
   logic             clr_c;

   function automatic logic [7:0] init_byte(input logic [IDX_W-1:0] i);
      case (i)
         3'd0, 3'd1, 3'd2: init_byte = 8'h38;
         3'd3:             init_byte = 8'h0C;
         3'd4:             init_byte = 8'h01;
         default:          init_byte = 8'h06;
      endcase
   endfunction

   // Each phase lasts exactly the loaded count; it ends on the edge where cnt==1.
   assign last_c = (cnt == CNT_W'(1));
   // Clear/Home need the long settle; the output registers double as the byte latch.
   assign clr_c  = !rs && ((data == 8'h01) || (data == 8'h02));

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state  <= S_PWRUP;
         cnt    <= CNT_W'(P_PWRUP_CYC);
         idx    <= '0;
         ready  <= 1'b0;
         done   <= 1'b0;
         en     <= 1'b0;
         rs     <= 1'b0;
         data   <= 8'h00;
         lcd_on <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         idx    <= idx_n;
         ready  <= ready_n;
         done   <= done_n;
         en     <= en_n;
         rs     <= rs_n;
         data   <= data_n;
         lcd_on <= 1'b1;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt - CNT_W'(1);
      idx_n   = idx;
      ready_n = 1'b0;
      done_n  = done;
      en_n    = 1'b0;
      rs_n    = rs;
      data_n  = data;
      case (state)
         S_PWRUP: begin
            if (last_c) begin
               state_n = S_SETUP;
               cnt_n   = CNT_W'(P_SETUP_CYC);
               rs_n    = 1'b0;
               data_n  = init_byte(idx);
            end
         end
         S_SETUP: begin
            if (last_c) begin
               state_n = S_EN_HI;
               cnt_n   = CNT_W'(P_EN_CYC);
               en_n    = 1'b1;
            end
         end
         S_EN_HI: begin
            if (last_c) begin
               state_n = S_HOLD;
               cnt_n   = CNT_W'(P_HOLD_CYC);
            end else begin
               en_n    = 1'b1;
            end
         end
         S_HOLD: begin
            if (last_c) begin
               state_n = S_WAIT;
               cnt_n   = clr_c ? CNT_W'(P_CLR_WAIT_CYC) : CNT_W'(P_CMD_WAIT_CYC);
            end
         end
         S_WAIT: begin
            if (last_c) begin
               if (!done && (idx != IDX_W'(5))) begin
                  state_n = S_SETUP;
                  cnt_n   = CNT_W'(P_SETUP_CYC);
                  idx_n   = idx + IDX_W'(1);
                  rs_n    = 1'b0;
                  data_n  = init_byte(idx + IDX_W'(1));
               end else begin
                  state_n = S_IDLE;
                  cnt_n   = cnt;
                  done_n  = 1'b1;
                  ready_n = 1'b1;
               end
            end
         end
         S_IDLE: begin
            cnt_n   = cnt;
            ready_n = 1'b1;
            if (bus.req && ready) begin
               state_n = S_SETUP;
               cnt_n   = CNT_W'(P_SETUP_CYC);
               rs_n    = bus.rs;
               data_n  = bus.data;
               ready_n = 1'b0;
            end
         end
         default: begin
            state_n = S_PWRUP;
            cnt_n   = CNT_W'(P_PWRUP_CYC);
            idx_n   = '0;
         end
      endcase
   end

   assign bus.ready     = ready;
   assign bus.init_done = done;
   assign bus.lcd_on    = lcd_on;
   assign bus.lcd_en    = en;
   assign bus.lcd_rs    = rs;
   assign bus.lcd_rw    = 1'b0;
   assign bus.lcd_data  = data;
endmodule

// File: doc/lcd_ctrl.md
# lcd_ctrl

HD44780-compatible character-LCD sequencer that sits between the processor's LCD I/O register path and the board LCD pins. It runs the power-up initialisation sequence autonomously. It then accepts one command/data byte at a time through a valid/ready handshake, and produces correctly timed RS/RW/EN/DATA waveforms for each byte. While a transfer or its settle wait is in progress, it holds off further requests.

## Interface
- P_PWRUP_CYC, 750000: power-up wait before the first init command (15 ms @ 50 MHz); must be ≥1.
- P_SETUP_CYC, 2: cycles RS/DATA are stable with EN low before EN rises; must be ≥1.
- P_EN_CYC, 12: EN high pulse width in cycles; must be ≥1.
- P_HOLD_CYC, 2: cycles RS/DATA are held after EN falls; must be ≥1.
- P_CMD_WAIT_CYC, 2000: settle wait after a normal command/data byte (40 µs); must be ≥1.
- P_CLR_WAIT_CYC, 82000: settle wait after Clear (0x01) or Home (0x02) with RS=0 (1.64 ms); must be ≥1.
- i_clk  in  1  system clock; all state changes on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_req  in  1  request valid; a transfer is accepted on an edge where i_req=1 and o_ready=1.
- i_rs  in  1  register select for the request: 0=command, 1=data.
- i_data  in  8  byte to transfer.
- o_ready  out  1  controller idle and init complete; can accept a request.
- o_init_done  out  1  sticky flag; set when the init sequence finishes and cleared only by reset.
- o_lcd_on  out  1  LCD power enable; 1 from reset deassertion onward.
- o_lcd_en  out  1  LCD enable strobe.
- o_lcd_rs  out  1  LCD register select.
- o_lcd_rw  out  1  LCD read/write; always 0 (write-only).
- o_lcd_data  out  8  LCD data bus.

## Operation
- **States:** PWRUP, SETUP, EN_HI, HOLD, WAIT, IDLE.
- **Counters:**
  - One down-counter, sized to $clog2 of the largest parameter plus 1.
  - A 3-bit init index (0..5).
- **Reset:**
  - Asynchronously forces state to PWRUP, counter to P_PWRUP_CYC, and init index to 0.
  - Outputs during reset: o_ready=0, o_init_done=0, o_lcd_en=0, o_lcd_rs=0, o_lcd_rw=0, o_lcd_data=0x00, o_lcd_on=0.
  - While not in reset, o_lcd_on=1.
- **PWRUP:** counts P_PWRUP_CYC cycles, then starts transfer of init byte 0.
- **Init sequence (all RS=0):** 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06.
  - Each byte uses the same SETUP→EN_HI→HOLD→WAIT path as a host transfer.
  - After WAIT of index 5: set o_init_done and enter IDLE.
- **Transfer states:**
  - SETUP: P_SETUP_CYC cycles, EN=0, RS/DATA driven from the latched byte.
  - EN_HI: P_EN_CYC cycles, EN=1.
  - HOLD: P_HOLD_CYC cycles, EN=0, RS/DATA unchanged.
  - WAIT: P_CLR_WAIT_CYC if the latched RS=0 and data ∈ {0x01, 0x02}; otherwise P_CMD_WAIT_CYC.
- **Host transfer:**
  - On acceptance, i_rs and i_data are latched; state goes to SETUP on the same edge.
  - After WAIT, state returns to IDLE.
- **Outputs between transfers:** o_lcd_rs/o_lcd_data hold the last latched value in IDLE and during WAIT; o_lcd_en=1 only in EN_HI.
- **Requests while o_ready=0:** ignored (not queued, no error).
- **i_rs/i_data changes after acceptance:** no effect on the transfer in progress.
- **Reset during any state** (including mid-EN pulse): EN drops asynchronously and the full init sequence reruns after release.

## Timing
- o_ready is a registered output: 1 only in IDLE.
- Accept at edge N:
  - o_ready=0 after edge N.
  - EN rises after edge N+P_SETUP_CYC.
  - EN falls after edge N+P_SETUP_CYC+P_EN_CYC.
  - o_ready=1 again after edge N+P_SETUP_CYC+P_EN_CYC+P_HOLD_CYC+W, where W is the applicable wait.
- **Back-to-back:** a request held high is accepted on the first edge o_ready=1, so the minimum request period is SETUP+EN+HOLD+W cycles.
- **Init duration:** PWRUP + 6×(SETUP+EN+HOLD) + 5×CMD_WAIT + 1×CLR_WAIT cycles from the first rising edge after reset release.
  - o_ready and o_init_done both rise after that edge.
- No combinational path from inputs to outputs.

## Test plan
All scenarios use P_PWRUP_CYC=10, SETUP=1, EN=2, HOLD=1, CMD_WAIT=4, CLR_WAIT=8.
- **Reset/init:**
  - Stimulus: assert i_reset, release.
  - During reset: all outputs 0.
  - Six EN pulses appear, each 2 cycles wide, carrying bytes 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 with RS=0.
  - o_ready and o_init_done rise after edge 62.
- **Single data write:**
  - Stimulus: after init, i_req=1, i_rs=1, i_data=0x41 for one cycle.
  - Response: one 2-cycle EN pulse with RS=1, DATA=0x41; o_ready low for exactly 8 cycles.
- **Clear wait:**
  - Stimulus: i_rs=0, i_data=0x01.
  - Response: o_ready low for 12 cycles.
  - Repeat with 0x02 → 12 cycles; 0x80 → 8 cycles; i_rs=1, i_data=0x01 → 8 cycles.
- **Back-to-back and ignored request:**
  - Stimulus: hold i_req=1 with bytes 0x48 then 0x49; toggle i_data to 0xFF mid-transfer.
  - Response: exactly two EN pulses, DATA=0x48 then 0x49, 8 cycles apart; 0xFF never appears on o_lcd_data.
- **Pre-init request:**
  - Stimulus: i_req=1 during PWRUP.
  - Response: no extra EN pulse; the init sequence proceeds unchanged.
- **Reset mid-pulse:**
  - Stimulus: assert i_reset while o_lcd_en=1.
  - Response: o_lcd_en=0 immediately (before the next edge); after release, the full init sequence repeats in 62 cycles.
